// File: rtl/bus_result_monitor.sv
// Passive CPU-bus monitor: turns a regression run into a registered verdict
// (PASS, FAIL, TIMEOUT or TRAP) from mailbox writes, self-loops and a cycle budget.
module bus_result_monitor #(
  parameter logic [15:0] MAILBOX_ADDR   = 16'h0040,
  parameter logic [7:0]  PASS_VALUE     = 8'h42,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TRAP_REPEAT    = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 ph1,
  input  logic                 resetb,
  input  logic [15:0]          address,
  input  logic [7:0]           data_out,
  input  logic                 memwrite,
  input  logic                 sync,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic                 trap,
  output logic [7:0]           result,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [7:0]           writes
);

  localparam int unsigned REP_W = (TRAP_REPEAT > 2) ? $clog2(TRAP_REPEAT) : 1;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PASS    = 3'd1,
    S_FAIL    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_TRAP    = 3'd4
  } state_t;

  state_t            state;
  logic [REP_W-1:0]  rep;
  logic [15:0]       last_fetch;

  logic mailbox_hit_c;
  logic same_fetch_c;
  logic trap_hit_c;
  logic timeout_hit_c;

  // Event decode; only consumed by the registered update below.
  always_comb begin
    mailbox_hit_c = memwrite && (address == MAILBOX_ADDR);
    same_fetch_c  = sync && (address == last_fetch);
    trap_hit_c    = same_fetch_c && (rep == REP_W'(TRAP_REPEAT - 2));
    timeout_hit_c = (cycles == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  // Verdict FSM; every output is a register and freezes once a verdict is taken.
  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state      <= S_RUN;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      trap       <= 1'b0;
      result     <= 8'h00;
      cycles     <= '0;
      writes     <= 8'h00;
      rep        <= '0;
      last_fetch <= 16'h0000;
    end else if (state == S_RUN) begin
      cycles <= cycles + CNT_WIDTH'(1);
      if (memwrite && (writes != 8'hFF))
        writes <= writes + 8'd1;

      if (sync) begin
        last_fetch <= address;
        if (!same_fetch_c)
          rep <= '0;
        else if (rep != REP_W'(TRAP_REPEAT - 1))
          rep <= rep + REP_W'(1);
      end

      // Mailbox write outranks a trap or timeout landing on the same edge.
      if (mailbox_hit_c) begin
        result <= data_out;
        done   <= 1'b1;
        if (data_out == PASS_VALUE) begin
          pass  <= 1'b1;
          state <= S_PASS;
        end else begin
          fail  <= 1'b1;
          state <= S_FAIL;
        end
      end else if (trap_hit_c) begin
        trap  <= 1'b1;
        fail  <= 1'b1;
        done  <= 1'b1;
        state <= S_TRAP;
      end else if (timeout_hit_c) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        cycles  <= CNT_WIDTH'(TIMEOUT_CYCLES);
        state   <= S_TIMEOUT;
      end
    end
  end

endmodule
